ap_chain_arbiter: RTL
=====================

Name: ap_chain_arbiter

Overview:
- Shares one ap_ctrl_chain-style register-access slave (addr / wr_data / rd_wr, ap_start / ap_continue / ap_ce, ap_idle / ap_ready / ap_done / ap_return) between NREQ requesters.
- Round-robin grant; runs the full start/ready/done/continue handshake per transaction and returns read data or error per requester.
- Sits between test-harness requesters and the wrapped DUT.

Parameters:
- NREQ, 2, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max ap_ce-enabled cycles in START without ap_ready before abort (>=4)

Ports:
- clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  request valid per requester
- req_ready  out  NREQ  request accepted (one-hot or zero)
- req_rd_wr  in  NREQ  1=read, 0=write per requester
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data
- rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester
- rsp_rdata  out  DW  read data, valid with rsp_valid (0 for writes/errors)
- rsp_err  out  1  timeout flag, valid with rsp_valid
- err_cnt  out  8  saturating timeout count
- ce_en  in  1  global enable, driven to ap_ce
- addr, wr_data, rd_wr  out  AW, DW, 1  to slave, held stable from START until IDLE
- ap_start, ap_continue, ap_ce  out  1 each  to slave
- ap_return  in  DW; ap_idle, ap_ready, ap_done  in  1 each  from slave

Behaviour:
- Reset (ap_rst sampled high at posedge): state=IDLE, rr pointer=0, all outputs 0 except ap_ce=ce_en, err_cnt=0, latched addr/wdata/rd_wr=0. Reset mid-transaction aborts without a response.
- States: IDLE, START, DRAIN, RESP.
- IDLE: req_ready[g]=1 only for the rr winner g, and only when ap_idle=1. On req_valid[g]&&req_ready[g]: latch addr/wdata/rd_wr/owner, set pointer to g+1 mod NREQ, go to START. If no winner, hold.
- START: ap_start=1, timeout counter increments while ce_en=1.
  - On ap_ready&&ap_done: capture ap_return (reads only), go to DRAIN.
  - If counter==TIMEOUT-1 with no ap_ready: set err, err_cnt+1 (saturating at 255), go to RESP.
  - ap_ready wins over a timeout in the same cycle.
- DRAIN: ap_start=0, ap_continue=1. When ap_done==0, go to RESP.
- RESP: rsp_valid[owner]=1 for exactly one cycle, with rsp_rdata and rsp_err. Go to IDLE. ap_continue=0.
- ap_continue is never asserted outside DRAIN. ap_start is never asserted outside START.
- ce_en=0 freezes all state transitions and the timeout counter. Outputs hold.
- Latency, idle slave, ce_en=1:
  - read: accept at T0, rsp_valid at T5
  - write: accept at T0, rsp_valid at T6
  - next grant possible the cycle after RESP, once ap_idle=1
- Round-robin: search starts at the pointer. Pointer moves only on acceptance.
- A requester deasserting req_valid before it is granted is legal. Acceptance is a single-cycle handshake.

Decomposition:
- Package ap_chain_pkg: state enum {IDLE, START, DRAIN, RESP}, 2-bit encoding; ERR_CNT_W=8.
- Sub-module rr_arbiter (NREQ): inputs req, pointer, enable; outputs one-hot grant and index.
- The FSM, latches and timeout counter stay in the top module.

Test Plan:
- Single read: preload slave reg 0x4 = 0xDEADBEEF; req0 read addr 0x4 -> rsp_valid[0] pulses at T5, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write then read: req1 writes 0x12345678 to 0x8 (rsp at T6, rdata=0), then reads 0x8 -> rsp_rdata=0x12345678.
- Contention: req0 and req1 both valid continuously -> grants alternate 0,1,0,1; each gets a response; no overlap of ap_start.
- Timeout: slave model never raises ap_ready, TIMEOUT=16 -> rsp_valid after 16 START cycles, rsp_err=1, err_cnt=1, arbiter accepts next request.
- ce_en held low for 5 cycles mid-START -> completion delayed by exactly 5 cycles; no timeout; data correct.
- ap_rst asserted in DRAIN -> next cycle all outputs 0, no rsp_valid, state IDLE; a subsequent read completes normally.

Source files
------------

// File: rtl/ap_chain_pkg.sv
// Shared types for the ap_ctrl_chain arbiter: controller state encoding and
// error counter width.
package ap_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/ap_chain_arbiter_rr_arbiter.sv
// Round-robin requester selection: the search begins at ptr and wraps, so the
// requester just served has the lowest priority on the next pass.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int sel;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sel   = 0;
    if (enable) begin
      for (int k = 0; k < NREQ; k++) begin
        sel = int'(ptr) + k;
        if (sel >= NREQ) sel = sel - NREQ;
        if (!any && req[sel]) begin
          any        = 1'b1;
          grant[sel] = 1'b1;
          idx        = IW'(sel);
        end
      end
    end
  end

endmodule

// File: rtl/ap_chain_arbiter.sv
// Shares one ap_ctrl_chain register-access slave between NREQ requesters,
// running the full start/ready/done/continue handshake for each transaction.
module ap_chain_arbiter
  import ap_chain_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             ap_rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ-1:0]  req_rd_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic             ce_en,
  output logic [AW-1:0]    addr,
  output logic [DW-1:0]    wr_data,
  output logic             rd_wr,
  output logic             ap_start,
  output logic             ap_continue,
  output logic             ap_ce,
  input  logic [DW-1:0]    ap_return,
  input  logic             ap_idle,
  input  logic             ap_ready,
  input  logic             ap_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, owner, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            gnt_any, arb_en;
  logic [TW-1:0]   to_cnt;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q, rdata_q;
  logic            rd_wr_q, err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic            accept, complete, expire;

  // Grants are offered only in IDLE with an idle slave; ce_en=0 must also
  // block them, otherwise a handshake would be lost while the FSM is frozen.
  assign arb_en = (state == IDLE) && ap_idle && ce_en;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req    (req_valid),
    .ptr    (ptr),
    .enable (arb_en),
    .grant  (gnt),
    .idx    (gnt_idx),
    .any    (gnt_any)
  );

  assign req_ready = gnt;
  assign accept    = gnt_any;
  assign complete  = (state == START) && ce_en && ap_ready && ap_done;
  assign expire    = (state == START) && ce_en && !ap_ready && (to_cnt == TO_LAST);

  assign ap_ce   = ce_en;
  assign addr    = addr_q;
  assign wr_data = wdata_q;
  assign rd_wr   = rd_wr_q;
  assign err_cnt = err_cnt_q;

  always_ff @(posedge clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    ap_start    = 1'b0;
    ap_continue = 1'b0;
    rsp_valid   = '0;
    rsp_rdata   = '0;
    rsp_err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = START;
      end
      START: begin
        ap_start = 1'b1;
        if (complete)    state_nx = DRAIN;
        else if (expire) state_nx = RESP;
      end
      DRAIN: begin
        ap_continue = 1'b1;
        if (ce_en && !ap_done) state_nx = RESP;
      end
      RESP: begin
        for (int i = 0; i < NREQ; i++) rsp_valid[i] = (owner == IW'(i));
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        if (ce_en) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Transaction latches, pointer and timeout counter
  always_ff @(posedge clk) begin
    if (ap_rst) begin
      ptr       <= '0;
      owner     <= '0;
      to_cnt    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_wr_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr[gnt_idx*AW +: AW];
        wdata_q <= req_wdata[gnt_idx*DW +: DW];
        rd_wr_q <= req_rd_wr[gnt_idx];
        owner   <= gnt_idx;
        ptr     <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        to_cnt  <= '0;
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if ((state == START) && ce_en) begin
        to_cnt <= to_cnt + 1'b1;
        if (complete) rdata_q <= rd_wr_q ? ap_return : '0;
        if (expire) begin
          err_q     <= 1'b1;
          err_cnt_q <= sat_inc(err_cnt_q);
        end
      end
    end
  end

endmodule
